// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment patterns and sizing helper for the 7-segment
// scanner. Patterns are active-high (1 = lit), bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG7_HEX [16] = '{
    7'h3F,  // 0 abcdef
    7'h06,  // 1 bc
    7'h5B,  // 2 abdeg
    7'h4F,  // 3 abcdg
    7'h66,  // 4 bcfg
    7'h6D,  // 5 acdfg
    7'h7D,  // 6 acdefg
    7'h07,  // 7 abc
    7'h7F,  // 8 all
    7'h6F,  // 9 abcdfg
    7'h77,  // A abcefg
    7'h7C,  // b cdefg
    7'h39,  // C adef
    7'h5E,  // d bcdeg
    7'h79,  // E adefg
    7'h71   // F aefg
  };

  // No segment lit
  localparam logic [6:0] SEG7_OFF = 7'h00;

  // Width of a digit index; never below 1 bit
  function automatic int seg7_dig_w(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// seg7_hex_dec: nibble to active-low segment drive {g,f,e,d,c,b,a}.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg_n
);

  // Table lookup, inverted for active-low pins
  assign o_seg_n = ~SEG7_HEX[i_nib];

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: multiplexed seven-segment scanner.
// DIGITS common-enable digits, each enabled for DIV clocks. New data is
// captured into a pending register and only moved into the displayed
// shadow register at a frame boundary (or while busy), so a frame never
// mixes old and new values.
// Optional feature: define SEG7_LZB_EN for leading-zero blanking.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int DIV    = 10000
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  busy,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  output logic [DIGITS-1:0]     led_en,
  output logic                  led_ca,
  output logic                  led_cb,
  output logic                  led_cc,
  output logic                  led_cd,
  output logic                  led_ce,
  output logic                  led_cf,
  output logic                  led_cg,
  output logic                  led_dp
);

  localparam int DIG_W = seg7_dig_w(DIGITS);
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
  localparam logic [DIG_W-1:0] DIG_MAX = DIG_W'(DIGITS - 1);

  typedef struct packed {
    logic [DIGITS-1:0]   blank;
    logic [DIGITS-1:0]   dp;
    logic [4*DIGITS-1:0] data;
  } frame_t;

  logic [PRE_W-1:0] r_pre;
  logic [DIG_W-1:0] r_dig;
  frame_t           r_pend;
  frame_t           r_shadow;
  logic             r_pend_vld;

  logic [DIGITS-1:0] r_led_en;
  logic [6:0]        r_seg_n;
  logic              r_dp_n;

  logic              w_tick;
  logic              w_xfer;
  logic [3:0]        w_nibs [DIGITS];
  logic [3:0]        w_nib;
  logic [6:0]        w_seg_n;
  logic              w_lz_dark;
  logic              w_dark;
  logic [DIGITS-1:0] w_en_n;

  assign w_tick = (r_pre == PRE_MAX);
  // Frame boundary, or busy (display is dark anyway, so updating is free)
  assign w_xfer = busy | (w_tick & (r_dig == DIG_MAX));

  // Prescaler and digit counter; busy parks both at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_dig <= '0;
    end else if (busy) begin
      r_pre <= '0;
      r_dig <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
      r_dig <= (r_dig == DIG_MAX) ? '0 : r_dig + DIG_W'(1);
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // Pending/shadow double buffer; a load coinciding with a transfer keeps
  // the new value pending while the shadow takes the older one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend     <= '0;
      r_shadow   <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      if (w_xfer && r_pend_vld)
        r_shadow <= r_pend;
      if (load) begin
        r_pend     <= {blank, dp_in, data};
        r_pend_vld <= 1'b1;
      end else if (w_xfer) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  // Split shadow data into per-digit nibbles
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    assign w_nibs[gi] = r_shadow.data[4*gi +: 4];
  end

  assign w_nib = w_nibs[r_dig];

  seg7_hex_dec u_dec (
    .i_nib   (w_nib),
    .o_seg_n (w_seg_n)
  );

`ifdef SEG7_LZB_EN
  // w_lz[i]: nibble i and every higher nibble are zero
  logic [DIGITS-1:0] w_lz;
  assign w_lz[DIGITS-1] = (w_nibs[DIGITS-1] == 4'h0);
  for (genvar gi = 0; gi < DIGITS-1; gi++) begin : g_lz
    assign w_lz[gi] = (w_nibs[gi] == 4'h0) & w_lz[gi+1];
  end
  // Digit 0 always shows so a zero value still reads "0"
  assign w_lz_dark = w_lz[r_dig] & (r_dig != '0);
`else
  assign w_lz_dark = 1'b0;
`endif

  assign w_dark = r_shadow.blank[r_dig] | w_lz_dark;
  assign w_en_n = ~(DIGITS'(1) << r_dig);

  // Output registers: one clock behind r_dig/shadow, enables and segments
  // switch on the same edge; dark slots still consume their time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led_en <= '1;
      r_seg_n  <= ~SEG7_OFF;
      r_dp_n   <= 1'b1;
    end else if (busy || w_dark) begin
      r_led_en <= '1;
      r_seg_n  <= ~SEG7_OFF;
      r_dp_n   <= 1'b1;
    end else begin
      r_led_en <= w_en_n;
      r_seg_n  <= w_seg_n;
      r_dp_n   <= ~r_shadow.dp[r_dig];
    end
  end

  assign led_en = r_led_en;
  assign led_ca = r_seg_n[0];
  assign led_cb = r_seg_n[1];
  assign led_cc = r_seg_n[2];
  assign led_cd = r_seg_n[3];
  assign led_ce = r_seg_n[4];
  assign led_cf = r_seg_n[5];
  assign led_cg = r_seg_n[6];
  assign led_dp = r_dp_n;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: directed checks of the scanner with DIGITS=4, DIV=4.
module tb_seg7_scan_mux;

`ifdef SEG7_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy;
  logic        load;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic [3:0]  led_en;
  logic        led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp;
  logic [6:0]  seg;

  int n_vec = 0;
  int n_err = 0;

  assign seg = {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca};

  always #5 clk = ~clk;

  seg7_scan_mux #(.DIGITS(4), .DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .busy(busy), .load(load),
    .data(data), .dp_in(dp_in), .blank(blank),
    .led_en(led_en),
    .led_ca(led_ca), .led_cb(led_cb), .led_cc(led_cc), .led_cd(led_cd),
    .led_ce(led_ce), .led_cf(led_cf), .led_cg(led_cg), .led_dp(led_dp)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One busy cycle: afterwards pre=0, dig=0 and the next edge is slot edge 1
  task automatic resync();
    busy = 1'b1;
    step();
    busy = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_en;
    logic [6:0] exp_seg;
    int k;
    rst_n = 1'b0; busy = 1'b0; load = 1'b0;
    data = 16'h0000; dp_in = 4'b0000; blank = 4'b0000;
    repeat (3) step();
    n_vec++;
    if (led_en !== 4'b1111) begin n_err++; $display("FAIL reset_en got %b want 1111", led_en); end
    n_vec++;
    if (seg !== 7'h7F) begin n_err++; $display("FAIL reset_seg got %h want 7f", seg); end
    n_vec++;
    if (led_dp !== 1'b1) begin n_err++; $display("FAIL reset_dp got %b want 1", led_dp); end
    rst_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      step();
      k = (e - 1) / 4;
      exp_en  = (LZB && k > 0) ? 4'b1111 : ~(4'b0001 << k);
      exp_seg = (LZB && k > 0) ? 7'h7F : 7'h40;
      n_vec++;
      if (led_en !== exp_en) begin n_err++; $display("FAIL scan_en e=%0d got %b want %b", e, led_en, exp_en); end
      n_vec++;
      if (seg !== exp_seg) begin n_err++; $display("FAIL scan_seg e=%0d got %h want %h", e, seg, exp_seg); end
    end
  endtask

  task automatic test_load_midframe();
    logic [6:0] exp_new [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};  // F A 2 1
    logic [3:0] exp_en;
    logic [6:0] exp_seg;
    logic       exp_dp;
    int k;
    resync();
    for (int e = 1; e <= 32; e++) begin
      step();
      k = ((e - 1) / 4) % 4;
      if (e >= 17) begin
        exp_en  = ~(4'b0001 << k);
        exp_seg = exp_new[k];
        exp_dp  = (k == 2) ? 1'b0 : 1'b1;
        n_vec++;
        if (led_en !== exp_en) begin n_err++; $display("FAIL load_en e=%0d got %b want %b", e, led_en, exp_en); end
        n_vec++;
        if (seg !== exp_seg) begin n_err++; $display("FAIL load_seg e=%0d got %h want %h", e, seg, exp_seg); end
        n_vec++;
        if (led_dp !== exp_dp) begin n_err++; $display("FAIL load_dp e=%0d got %b want %b", e, led_dp, exp_dp); end
      end else if (e >= 6 && k == 0) begin
        // old (all-zero) frame still on display until the boundary
        n_vec++;
        if (seg !== 7'h40) begin n_err++; $display("FAIL hold_seg e=%0d got %h want 40", e, seg); end
      end else if (e >= 6 && !LZB) begin
        n_vec++;
        if (seg !== 7'h40 || led_dp !== 1'b1) begin
          n_err++; $display("FAIL hold_seg e=%0d got %h/%b want 40/1", e, seg, led_dp);
        end
      end
      if (e == 5) begin
        load = 1'b1; data = 16'h12AF; dp_in = 4'b0100;
      end else begin
        load = 1'b0;
      end
    end
  endtask

  // Continues the phase left by test_load_midframe (edge 32 = frame end)
  task automatic test_busy();
    for (int e = 33; e <= 42; e++) begin
      step();
      if (e <= 34) begin
        n_vec++;
        if (led_en !== 4'b1110 || seg !== 7'h0E) begin
          n_err++; $display("FAIL pre_busy e=%0d got %b/%h want 1110/0e", e, led_en, seg);
        end
      end else if (e <= 37) begin
        n_vec++;
        if (led_en !== 4'b1111 || seg !== 7'h7F || led_dp !== 1'b1) begin
          n_err++; $display("FAIL busy_dark e=%0d got %b/%h/%b want 1111/7f/1", e, led_en, seg, led_dp);
        end
      end else if (e <= 41) begin
        n_vec++;
        if (led_en !== 4'b1110 || seg !== 7'h02) begin
          n_err++; $display("FAIL busy_restart e=%0d got %b/%h want 1110/02", e, led_en, seg);
        end
      end else begin
        n_vec++;
        if (led_en !== 4'b1101 || seg !== 7'h12) begin
          n_err++; $display("FAIL busy_next e=%0d got %b/%h want 1101/12", e, led_en, seg);
        end
      end
      if (e == 33) begin
        load = 1'b1; data = 16'h3456; dp_in = 4'b0000;
      end else if (e == 34) begin
        load = 1'b0; busy = 1'b1;
      end else if (e == 37) begin
        busy = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_en;
    logic [6:0] exp_seg;
    int k;
    resync();
    for (int e = 1; e <= 48; e++) begin
      step();
      k = ((e - 1) / 4) % 4;
      if (e >= 17) begin
        exp_en  = ~(4'b0001 << k);
        exp_seg = (e <= 32) ? 7'h79 : 7'h24;
        n_vec++;
        if (led_en !== exp_en) begin n_err++; $display("FAIL b2b_en e=%0d got %b want %b", e, led_en, exp_en); end
        n_vec++;
        if (seg !== exp_seg) begin n_err++; $display("FAIL b2b_seg e=%0d got %h want %h", e, seg, exp_seg); end
      end
      if (e == 1) begin
        load = 1'b1; data = 16'h1111;
      end else if (e == 15) begin
        load = 1'b1; data = 16'h2222;
      end else begin
        load = 1'b0;
      end
    end
  endtask

  task automatic test_blank();
    logic [3:0] exp_en;
    int k;
    load = 1'b1; data = 16'h1111; dp_in = 4'b0000; blank = 4'b1000;
    step();
    load = 1'b0; blank = 4'b0000;
    resync();
    for (int e = 1; e <= 20; e++) begin
      step();
      k = ((e - 1) / 4) % 4;
      exp_en = (k == 3) ? 4'b1111 : ~(4'b0001 << k);
      n_vec++;
      if (led_en !== exp_en) begin n_err++; $display("FAIL blank_en e=%0d got %b want %b", e, led_en, exp_en); end
    end
  endtask

  task automatic test_lzb();
    logic [3:0] exp_en;
    logic [6:0] exp_seg;
    int k;
    load = 1'b1; data = 16'h0050; dp_in = 4'b0000; blank = 4'b0000;
    step();
    load = 1'b0;
    resync();
    for (int e = 1; e <= 16; e++) begin
      step();
      k = (e - 1) / 4;
      if (k >= 2 && LZB) begin
        exp_en = 4'b1111; exp_seg = 7'h7F;
      end else begin
        exp_en  = ~(4'b0001 << k);
        exp_seg = (k == 1) ? 7'h12 : 7'h40;
      end
      n_vec++;
      if (led_en !== exp_en) begin n_err++; $display("FAIL lzb_en e=%0d got %b want %b", e, led_en, exp_en); end
      n_vec++;
      if (seg !== exp_seg) begin n_err++; $display("FAIL lzb_seg e=%0d got %h want %h", e, seg, exp_seg); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [3:0] exp_en;
    logic [6:0] exp_seg;
    int k;
    resync();
    repeat (5) step();
    load = 1'b1; data = 16'h8888;
    step();
    load = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (led_en !== 4'b1111 || seg !== 7'h7F || led_dp !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_dark got %b/%h/%b want 1111/7f/1", led_en, seg, led_dp);
    end
    step();
    rst_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      k = ((e - 1) / 4) % 4;
      exp_en  = (LZB && k > 0) ? 4'b1111 : ~(4'b0001 << k);
      exp_seg = (LZB && k > 0) ? 7'h7F : 7'h40;
      n_vec++;
      if (led_en !== exp_en || seg !== exp_seg) begin
        n_err++; $display("FAIL rst_mid_lost e=%0d got %b/%h want %b/%h", e, led_en, seg, exp_en, exp_seg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_midframe();
    test_busy();
    test_back_to_back();
    test_blank();
    test_lzb();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
